pri_decoder: RTL and testbench

Inverse of pri_encoder: converts a stream of binary bit indices back into one-hot vectors and accumulates them into a sticky request mask. It sits downstream of pri_encoder, or anywhere an index must be re-expanded into a bit-vector request. It has a 2-stage registered pipeline, enable-based stall, an occupancy FSM on the mask, and range checking for non-power-of-2 widths.

---
 rtl/pri_pkg.sv | 25 ++
 rtl/pri_decoder_onehot_dec.sv | 24 ++
 rtl/pri_decoder.sv | 130 +++++++++++++
 tb/tb_pri_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// pri_pkg: shared types and width helpers for pri_encoder / pri_decoder.
// Exports the mask occupancy state enum and clog2-based width functions.
package pri_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } mask_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // An index bus is never narrower than one bit, even for DWIDTH == 1.
  function automatic int idx_width(input int n);
    int r;
    r = clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pri_decoder_onehot_dec.sv
// onehot_dec: combinational bit index -> one-hot expansion with range flag.
// idx_i: index; onehot_o: 1 << idx_i (0 when out of range); oor_o: idx_i >= DWIDTH.
module onehot_dec #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 3
) (
  input  logic [IWIDTH-1:0] idx_i,
  output logic [DWIDTH-1:0] onehot_o,
  output logic              oor_o
);

  localparam logic [IWIDTH:0] LIMIT = (IWIDTH+1)'(DWIDTH);

  // Only indices below DWIDTH can match a bit, so an
  // out-of-range index naturally yields an all-zero vector.
  always_comb begin
    oor_o    = ({1'b0, idx_i} >= LIMIT);
    onehot_o = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      onehot_o[i] = (idx_i == IWIDTH'(i));
    end
  end

endmodule

// File: rtl/pri_decoder.sv
// pri_decoder: pipelined index -> one-hot decoder with a sticky request mask.
// In: clk, rst, enable, clear, din, din_v. Out: dout, dout_v, err, mask, mask_cnt, mask_full, mask_empty.
module pri_decoder
  import pri_pkg::*;
#(
  parameter  int DWIDTH = 8,
  localparam int IWIDTH = idx_width(DWIDTH),
  localparam int CWIDTH = clog2(DWIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [IWIDTH-1:0] din,
  input  logic              din_v,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_v,
  output logic              err,
  output logic [DWIDTH-1:0] mask,
  output logic [CWIDTH-1:0] mask_cnt,
  output logic              mask_full,
  output logic              mask_empty
);

  localparam logic [CWIDTH-1:0] ALL_SET = CWIDTH'(DWIDTH);

  logic [IWIDTH-1:0] in_idx_q;
  logic              in_v_q;
  logic [IWIDTH-1:0] s1_idx_q;
  logic              s1_v_q;
  logic [DWIDTH-1:0] dout_q;
  logic              dout_v_q;
  logic              err_q;

  logic [DWIDTH-1:0] mask_q, mask_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  mask_state_e       state_q, state_d;

  logic [DWIDTH-1:0] dec;
  logic              oor;
  logic              upd;

  function automatic logic [CWIDTH-1:0] popcnt(
    input logic [DWIDTH-1:0] v
  );
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      c = c + CWIDTH'(v[i]);
    end
    return c;
  endfunction

  onehot_dec #(
    .DWIDTH (DWIDTH),
    .IWIDTH (IWIDTH)
  ) u_dec (
    .idx_i    (s1_idx_q),
    .onehot_o (dec),
    .oor_o    (oor)
  );

  // Input capture, index stage, decode stage: din sampled at
  // edge N shows on dout after edge N+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx_q <= '0;
      in_v_q   <= 1'b0;
      s1_idx_q <= '0;
      s1_v_q   <= 1'b0;
      dout_q   <= '0;
      dout_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (enable) begin
      in_idx_q <= din;
      in_v_q   <= din_v;
      s1_idx_q <= in_idx_q;
      s1_v_q   <= in_v_q;
      dout_q   <= s1_v_q ? dec : '0;
      dout_v_q <= s1_v_q;
      err_q    <= s1_v_q & oor;
    end
  end

  assign upd = enable & s1_v_q & ~oor;

  // Clear wins over the old mask but not over a same-edge update.
  always_comb begin
    mask_d = mask_q;
    if (clear) mask_d = '0;
    if (upd)   mask_d = mask_d | dec;
    cnt_d = popcnt(mask_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (clear & ~upd): state_d = EMPTY;
      upd:            state_d = (cnt_d == ALL_SET) ? FULL : PARTIAL;
      default:        state_d = state_q;
    endcase
  end

  always_comb begin
    mask_empty = (state_q == EMPTY);
    mask_full  = (state_q == FULL);
  end

  assign dout     = dout_q;
  assign dout_v   = dout_v_q;
  assign err      = err_q;
  assign mask     = mask_q;
  assign mask_cnt = cnt_q;

endmodule

// File: tb/tb_pri_decoder.sv
// tb_pri_decoder: directed bench for pri_decoder at DWIDTH=8 and DWIDTH=6.
// Both instances share stimulus; each step checks the instance it targets.
module tb_pri_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear;
  logic [2:0] din;
  logic       din_v;

  logic [7:0] d8_dout, d8_mask;
  logic       d8_dv, d8_err, d8_full, d8_empty;
  logic [3:0] d8_cnt;

  logic [5:0] d6_dout, d6_mask;
  logic       d6_dv, d6_err, d6_full, d6_empty;
  logic [2:0] d6_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_decoder #(.DWIDTH(8)) u8 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .din        (din),
    .din_v      (din_v),
    .dout       (d8_dout),
    .dout_v     (d8_dv),
    .err        (d8_err),
    .mask       (d8_mask),
    .mask_cnt   (d8_cnt),
    .mask_full  (d8_full),
    .mask_empty (d8_empty)
  );

  pri_decoder #(.DWIDTH(6)) u6 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .din        (din),
    .din_v      (din_v),
    .dout       (d6_dout),
    .dout_v     (d6_dv),
    .err        (d6_err),
    .mask       (d6_mask),
    .mask_cnt   (d6_cnt),
    .mask_full  (d6_full),
    .mask_empty (d6_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    din = '0;   din_v  = 1'b0;
    repeat (10) tick();
    chk("rst_dout",  32'(d8_dout),  32'h00);
    chk("rst_dv",    32'(d8_dv),    32'h0);
    chk("rst_err",   32'(d8_err),   32'h0);
    chk("rst_mask",  32'(d8_mask),  32'h00);
    chk("rst_cnt",   32'(d8_cnt),   32'h0);
    chk("rst_empty", 32'(d8_empty), 32'h1);
    chk("rst_full",  32'(d8_full),  32'h0);
    rst = 1'b0;

    // Sweep 0..7: index c-2 appears after the tick of step c.
    for (int c = 0; c < 10; c++) begin
      din   = 3'(c);
      din_v = (c < 8);
      tick();
      if (c >= 2) begin
        chk("sw_dv",   32'(d8_dv),   32'h1);
        chk("sw_dout", 32'(d8_dout), 32'h1 << (c - 2));
        chk("sw6_err", 32'(d6_err),  32'(c >= 8));
      end
    end
    chk("sw_mask",  32'(d8_mask),  32'hFF);
    chk("sw_cnt",   32'(d8_cnt),   32'd8);
    chk("sw_full",  32'(d8_full),  32'h1);
    chk("sw_empty", 32'(d8_empty), 32'h0);
    chk("sw6_mask", 32'(d6_mask),  32'h3F);
    chk("sw6_cnt",  32'(d6_cnt),   32'd6);
    chk("sw6_full", 32'(d6_full),  32'h1);

    din_v = 1'b0;
    tick(); tick();
    chk("drain_dv", 32'(d8_dv), 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr6_mask",  32'(d6_mask),  32'h00);
    chk("clr6_empty", 32'(d6_empty), 32'h1);
    chk("clr8_mask",  32'(d8_mask),  32'h00);

    // Out-of-range 6,7 then duplicate 3 on the 6-wide instance.
    din = 3'd6; din_v = 1'b1; tick();
    din = 3'd7; tick();
    din = 3'd3; tick();
    chk("r6_dv",   32'(d6_dv),   32'h1);
    chk("r6_err",  32'(d6_err),  32'h1);
    chk("r6_dout", 32'(d6_dout), 32'h00);
    chk("r6_mask", 32'(d6_mask), 32'h00);
    din = 3'd3; tick();
    chk("r7_err",  32'(d6_err),  32'h1);
    chk("r7_dout", 32'(d6_dout), 32'h00);
    chk("r7_mask", 32'(d6_mask), 32'h00);
    din_v = 1'b0; tick();
    chk("d3a_dout", 32'(d6_dout), 32'h08);
    chk("d3a_err",  32'(d6_err),  32'h0);
    chk("d3a_mask", 32'(d6_mask), 32'h08);
    tick();
    chk("d3b_dv",   32'(d6_dv),   32'h1);
    chk("d3b_mask", 32'(d6_mask), 32'h08);
    chk("d3b_cnt",  32'(d6_cnt),  32'd1);
    tick();
    chk("d3c_dv", 32'(d6_dv), 32'h0);

    clear = 1'b1; tick(); clear = 1'b0;

    // Stall with index 2 in flight.
    din = 3'd2; din_v = 1'b1; tick();
    din_v = 1'b0; enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("st_dv",   32'(d8_dv),   32'h0);
      chk("st_mask", 32'(d8_mask), 32'h00);
    end
    enable = 1'b1;
    tick();
    chk("st_e1_dv", 32'(d8_dv), 32'h0);
    tick();
    chk("st_e2_dv",   32'(d8_dv),   32'h1);
    chk("st_e2_dout", 32'(d8_dout), 32'h04);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_dv",   32'(d8_dv),   32'h1);
      chk("hold_dout", 32'(d8_dout), 32'h04);
      chk("hold_cnt",  32'(d8_cnt),  32'd1);
    end
    enable = 1'b1;
    tick();
    chk("post_dv", 32'(d8_dv), 32'h0);

    // Build F0, then collide clear with index 1 reaching S2.
    clear = 1'b1; tick(); clear = 1'b0;
    din_v = 1'b1;
    for (int k = 4; k < 8; k++) begin
      din = 3'(k);
      tick();
    end
    din_v = 1'b0;
    tick(); tick();
    chk("f0_mask", 32'(d8_mask), 32'hF0);
    chk("f0_cnt",  32'(d8_cnt),  32'd4);
    din = 3'd1; din_v = 1'b1; tick();
    din_v = 1'b0; tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("cc_mask",  32'(d8_mask),  32'h02);
    chk("cc_cnt",   32'(d8_cnt),   32'd1);
    chk("cc_dout",  32'(d8_dout),  32'h02);
    chk("cc_empty", 32'(d8_empty), 32'h0);
    chk("cc_full",  32'(d8_full),  32'h0);

    // Reset while indices 0,1 (and 2 presented) are in flight.
    tick();
    din = 3'd0; din_v = 1'b1; tick();
    din = 3'd1; tick();
    din = 3'd2; rst = 1'b1; tick();
    rst = 1'b0; din_v = 1'b0;
    chk("mr_mask",  32'(d8_mask),  32'h00);
    chk("mr_empty", 32'(d8_empty), 32'h1);
    chk("mr_dv0",   32'(d8_dv),    32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_dv", 32'(d8_dv), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
